// File: rtl/forward_path_cfg_ctrl_if.sv
// forward_path_cfg_ctrl_if: config write handshake and commit request/acknowledge bundle
interface forward_path_cfg_ctrl_if;
  logic cfg_valid;
  logic cfg_ready;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_chan;
  logic [7:0] cfg_tap;
  logic [15:0] cfg_data;
  logic commit_req;
  logic commit_ack;
  modport master(output cfg_valid, cfg_sel, cfg_chan, cfg_tap, cfg_data, commit_req, input cfg_ready, commit_ack);
  modport slave(input cfg_valid, cfg_sel, cfg_chan, cfg_tap, cfg_data, commit_req, output cfg_ready, commit_ack);
endinterface

// File: rtl/forward_path_cfg_ctrl.sv
// forward_path_cfg_ctrl: shadow/active config banks with atomic commit and datapath flush blanking
module forward_path_cfg_ctrl #(
  parameter int numChannels = 32,
  parameter int estDepth = 11,
  parameter int estBitwidth = 8,
  parameter int ffeDepth = 10,
  parameter int weightBitwidth = 10,
  parameter int threshBitwidth = 8,
  parameter int shiftBitwidth = 4,
  parameter int flushCycles = 4
) (
  input logic clk,
  input logic rst,
  forward_path_cfg_ctrl_if.slave cfg,
  output logic signed [estBitwidth-1:0] channel_est [numChannels][estDepth],
  output logic signed [weightBitwidth-1:0] weights [numChannels][ffeDepth],
  output logic signed [threshBitwidth-1:0] new_thresh [numChannels],
  output logic [shiftBitwidth-1:0] shift_index,
  output logic bits_valid,
  output logic busy,
  output logic addr_err
);
  localparam int CW = numChannels > 1 ? $clog2(numChannels) : 1;
  localparam int EW = estDepth > 1 ? $clog2(estDepth) : 1;
  localparam int FW = ffeDepth > 1 ? $clog2(ffeDepth) : 1;
  localparam int NW = $clog2(flushCycles + 1);
  typedef enum logic [1:0] {IDLE, COPY, FLUSH} state_e;
  state_e state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d, ack_q, ack_d, valid_q, valid_d, busy_q, busy_d, err_q;
  logic wr, bad;
  logic unused_data;
  logic signed [estBitwidth-1:0] est_sh_q [numChannels][estDepth];
  logic signed [estBitwidth-1:0] est_q [numChannels][estDepth];
  logic signed [weightBitwidth-1:0] w_sh_q [numChannels][ffeDepth];
  logic signed [weightBitwidth-1:0] w_q [numChannels][ffeDepth];
  logic signed [threshBitwidth-1:0] th_sh_q [numChannels];
  logic signed [threshBitwidth-1:0] th_q [numChannels];
  logic [shiftBitwidth-1:0] sh_sh_q, sh_q;
  assign wr = cfg.cfg_valid && ready_q;
  assign bad = int'(cfg.cfg_chan) >= numChannels
    || (cfg.cfg_sel == 2'd0 && int'(cfg.cfg_tap) >= estDepth)
    || (cfg.cfg_sel == 2'd1 && int'(cfg.cfg_tap) >= ffeDepth);
  assign unused_data = ^cfg.cfg_data;
  assign cfg.cfg_ready = ready_q;
  assign cfg.commit_ack = ack_q;
  assign channel_est = est_q;
  assign weights = w_q;
  assign new_thresh = th_q;
  assign shift_index = sh_q;
  assign bits_valid = valid_q;
  assign busy = busy_q;
  assign addr_err = err_q;
  always_comb begin
    ack_d = state_q == FLUSH && cnt_q == NW'(1);
    state_d = state_q == IDLE ? (cfg.commit_req ? COPY : IDLE) : state_q == COPY ? FLUSH : ack_d ? IDLE : FLUSH;
    cnt_d = state_q == COPY ? NW'(flushCycles) : state_q == FLUSH ? cnt_q - 1'b1 : cnt_q;
    ready_d = state_d == IDLE;
    busy_d = state_d != IDLE;
    valid_d = state_d == IDLE && (valid_q || ack_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ready_q <= 1'b0;
      ack_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      est_sh_q <= '{default: '0};
      est_q <= '{default: '0};
      w_sh_q <= '{default: '0};
      w_q <= '{default: '0};
      th_sh_q <= '{default: '0};
      th_q <= '{default: '0};
      sh_sh_q <= '0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
      ack_q <= ack_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      err_q <= err_q || (wr && bad);
      if (wr && !bad) begin
        if (cfg.cfg_sel == 2'd0) est_sh_q[cfg.cfg_chan[CW-1:0]][cfg.cfg_tap[EW-1:0]] <= cfg.cfg_data[estBitwidth-1:0];
        if (cfg.cfg_sel == 2'd1) w_sh_q[cfg.cfg_chan[CW-1:0]][cfg.cfg_tap[FW-1:0]] <= cfg.cfg_data[weightBitwidth-1:0];
        if (cfg.cfg_sel == 2'd2) th_sh_q[cfg.cfg_chan[CW-1:0]] <= cfg.cfg_data[threshBitwidth-1:0];
        if (cfg.cfg_sel == 2'd3) sh_sh_q <= cfg.cfg_data[shiftBitwidth-1:0];
      end
      // whole bank moves in one edge so the datapath never sees a mixed configuration
      if (state_q == COPY) begin
        est_q <= est_sh_q;
        w_q <= w_sh_q;
        th_q <= th_sh_q;
        sh_q <= sh_sh_q;
      end
    end
  end
endmodule

// File: tb/tb_forward_path_cfg_ctrl.sv
// tb_forward_path_cfg_ctrl: directed stimulus with a commit_ack scoreboard monitor
module tb_forward_path_cfg_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  forward_path_cfg_ctrl_if bus();
  logic signed [7:0] channel_est [32][11];
  logic signed [9:0] weights [32][10];
  logic signed [7:0] new_thresh [32];
  logic [3:0] shift_index;
  logic bits_valid, busy, addr_err;
  typedef struct {
    int ack_cyc;
    logic [9:0] w;
    logic [3:0] sh;
    logic [7:0] th;
    logic err;
  } exp_t;
  exp_t q [$];
  forward_path_cfg_ctrl dut (
    .clk(clk), .rst(rst), .cfg(bus.slave),
    .channel_est(channel_est), .weights(weights), .new_thresh(new_thresh),
    .shift_index(shift_index), .bits_valid(bits_valid), .busy(busy), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (bus.commit_ack) begin
      chk("ack_expected", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("ack_cycle", cyc, e.ack_cyc);
        chk("ack_w32", $unsigned(weights[3][2]), e.w);
        chk("ack_shift", shift_index, e.sh);
        chk("ack_th5", $unsigned(new_thresh[5]), e.th);
        chk("ack_err", addr_err, e.err);
        chk("ack_bits_valid", bits_valid, 1);
        chk("ack_busy", busy, 0);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic setw(input logic [1:0] s, input logic [7:0] c, input logic [7:0] t, input logic [15:0] d);
    bus.cfg_valid = 1'b1;
    bus.cfg_sel = s;
    bus.cfg_chan = c;
    bus.cfg_tap = t;
    bus.cfg_data = d;
  endtask
  task automatic wr(input logic [1:0] s, input logic [7:0] c, input logic [7:0] t, input logic [15:0] d);
    int n;
    setw(s, c, t, d);
    n = 0;
    @(negedge clk);
    while (!bus.cfg_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("wr_ready_timeout", 32'(bus.cfg_ready), 1);
    step();
    bus.cfg_valid = 1'b0;
  endtask
  task automatic push(input int lat, input logic [9:0] w, input logic [3:0] sh, input logic [7:0] th, input logic err);
    exp_t e;
    e.ack_cyc = cyc + lat;
    e.w = w;
    e.sh = sh;
    e.th = th;
    e.err = err;
    q.push_back(e);
  endtask
  task automatic drain();
    for (int i = 0; i < 30 && q.size() > 0; i++) @(negedge clk);
    chk("ack_timeout", q.size(), 0);
    step();
  endtask
  task automatic commit(input logic [9:0] w, input logic [3:0] sh, input logic [7:0] th, input logic err);
    bus.commit_req = 1'b1;
    push(6, w, sh, th, err);
    step();
    bus.commit_req = 1'b0;
    drain();
  endtask
  initial begin
    int n;
    bus.cfg_valid = 1'b0;
    bus.cfg_sel = '0;
    bus.cfg_chan = '0;
    bus.cfg_tap = '0;
    bus.cfg_data = '0;
    bus.commit_req = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_ready", bus.cfg_ready, 0);
    chk("rst_ack", bus.commit_ack, 0);
    chk("rst_bits_valid", bits_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_w32", $unsigned(weights[3][2]), 0);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_ready", bus.cfg_ready, 1);
    chk("post_rst_bits_valid", bits_valid, 0);
    step();
    wr(2'd1, 8'd3, 8'd2, 16'h01F5);
    @(negedge clk);
    chk("w32_before_commit", $unsigned(weights[3][2]), 0);
    step();
    commit(10'h1F5, 4'd0, 8'd0, 1'b0);
    wr(2'd0, 8'd32, 8'd0, 16'h0055);
    @(negedge clk);
    chk("bad_chan_err", addr_err, 1);
    chk("bad_chan_est00", $unsigned(channel_est[0][0]), 0);
    chk("bad_chan_w32", $unsigned(weights[3][2]), 10'h1F5);
    step();
    wr(2'd1, 8'd3, 8'd20, 16'h0003);
    commit(10'h1F5, 4'd0, 8'd0, 1'b1);
    setw(2'd3, 8'd0, 8'd0, 16'd5);
    bus.commit_req = 1'b1;
    push(6, 10'h1F5, 4'd5, 8'd0, 1'b1);
    step();
    bus.cfg_valid = 1'b0;
    bus.commit_req = 1'b0;
    drain();
    bus.commit_req = 1'b1;
    push(6, 10'h1F5, 4'd5, 8'd0, 1'b1);
    step();
    bus.commit_req = 1'b0;
    setw(2'd2, 8'd5, 8'd0, 16'h007A);
    n = 0;
    @(negedge clk);
    while (!bus.cfg_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", n, 5);
    step();
    bus.cfg_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("stall_th5_not_active", $unsigned(new_thresh[5]), 0);
    step();
    commit(10'h1F5, 4'd5, 8'h7A, 1'b1);
    wr(2'd1, 8'd3, 8'd2, 16'h00AA);
    bus.commit_req = 1'b1;
    step();
    bus.commit_req = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("abort_ack", bus.commit_ack, 0);
    chk("abort_w32", $unsigned(weights[3][2]), 0);
    chk("abort_shift", shift_index, 0);
    chk("abort_th5", $unsigned(new_thresh[5]), 0);
    chk("abort_bits_valid", bits_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", addr_err, 0);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("abort_ready", bus.cfg_ready, 1);
    step();
    wr(2'd3, 8'd0, 8'd0, 16'd9);
    bus.commit_req = 1'b1;
    push(6, 10'h0, 4'd9, 8'd0, 1'b0);
    push(12, 10'h0, 4'd9, 8'd0, 1'b0);
    push(18, 10'h0, 4'd9, 8'd0, 1'b0);
    n = 0;
    for (int i = 0; i < 18; i++) begin
      step();
      if (i == 12) bus.commit_req = 1'b0;
      @(negedge clk);
      if (bits_valid) n++;
    end
    chk("held_bits_valid_count", n, 3);
    drain();
    repeat (10) step();
    chk("final_queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
